// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the multi-port register file
// with a pending-write scoreboard.
//   DW_DEF / DEPTH_DEF / NR_DEF / NW_DEF / CW_DEF : default geometry
//   ZERO_REG   : index of the hardwired-zero register
//   pend_cnt_t : pending-write counter at the default counter width
package rf_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NR_DEF    = 2;
  localparam int NW_DEF    = 1;
  localparam int CW_DEF    = 2;

  localparam int unsigned ZERO_REG = 0;

  typedef logic [CW_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/rf_sb_counter.sv
// rf_sb_counter: pending-write counter for one register.
//   clk, rst      : clock, asynchronous active-low reset
//   flush_i       : clear the counter on the next edge (beats inc/dec)
//   inc_i         : one allocation accepted this cycle
//   dec_i[NW]     : one release per write port this cycle
//   cnt_o[CW]     : registered counter value
// Increment and all decrements are summed into a single net change; the
// result saturates at 0 and at 2^CW-1.
module rf_sb_counter
  import rf_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          inc_i,
  input  logic [NW-1:0] dec_i,
  output logic [CW-1:0] cnt_o
);

  localparam int CNT_MAX = (1 << CW) - 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  int            ndec;
  int            net;
  logic          underflow;

  always_comb begin
    ndec = 0;
    for (int w = 0; w < NW; w++) begin
      ndec = ndec + (dec_i[w] ? 1 : 0);
    end
    net       = int'(cnt_q) + (inc_i ? 1 : 0) - ndec;
    underflow = (net < 0);
    if (flush_i)             cnt_d = '0;
    else if (net < 0)        cnt_d = '0;
    else if (net > CNT_MAX)  cnt_d = '1;
    else                     cnt_d = CW'(net);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // A release with nothing outstanding means issue/writeback bookkeeping
  // has gone wrong upstream; a flush legitimately discards that state.
  always_ff @(posedge clk) begin
    if (rst && !flush_i) begin
      assert (!underflow);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rf_mp_sb.sv
// rf_mp_sb: NR-read / NW-write register file with per-register pending
// write scoreboard used by issue for RAW interlock.
//   clk, rst               : clock, asynchronous active-low reset
//   rd_addr/rd_data        : NR combinational read ports
//   rd_ready               : 1 = no pending write to the addressed register
//   wr_en/wr_addr/wr_data  : NW write ports, highest index wins on conflict
//   wr_rel                 : write also releases one scoreboard entry
//   alloc_en/alloc_addr    : issue allocates a pending write
//   alloc_stall            : allocation refused, counter saturated
//   flush                  : clear all pending counters
// Optional: define RF_MP_BYPASS_EN to forward same-cycle write data (and
// a same-cycle final release) to the read ports.
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int NR    = NR_DEF,
  parameter int NW    = NW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_ready,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic [NW-1:0]    wr_rel,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_addr,
  output logic             alloc_stall,
  input  logic             flush
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [DW-1:0]                mem_q [DEPTH];
  logic [DEPTH-1:0][CW-1:0]     cnt;
  logic [DEPTH-1:0][NW-1:0]     rel;
  logic [DEPTH-1:0]             inc;

  // Release vectors per register; register 0 never carries a counter.
  always_comb begin
    rel = '0;
    for (int i = 1; i < DEPTH; i++) begin
      for (int w = 0; w < NW; w++) begin
        rel[i][w] = wr_en[w] & wr_rel[w] & (wr_addr[w*AW +: AW] == AW'(i));
      end
    end
  end

  // A same-cycle release frees a slot, so a saturated counter can still
  // accept the allocation (net change 0).
  assign alloc_stall = alloc_en & (cnt[alloc_addr] == {CW{1'b1}}) & ~(|rel[alloc_addr]);

  always_comb begin
    inc = '0;
    for (int i = 1; i < DEPTH; i++) begin
      inc[i] = alloc_en & ~alloc_stall & (alloc_addr == AW'(i));
    end
  end

  assign cnt[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cnt
    rf_sb_counter #(
      .CW (CW),
      .NW (NW)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .inc_i   (inc[i]),
      .dec_i   (rel[i]),
      .cnt_o   (cnt[i])
    );
  end

  // Later ports are visited last, so their non-blocking write lands last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != ZERO_A)) begin
          mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*DW +: DW];
        end
      end
    end
  end

`ifdef RF_MP_BYPASS_EN
  logic [NR-1:0] fwd_rel;
`endif

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
`ifdef RF_MP_BYPASS_EN
    fwd_rel  = '0;
`endif
    for (int k = 0; k < NR; k++) begin
      rd_data[k*DW +: DW] = (rd_addr[k*AW +: AW] == ZERO_A) ? '0 : mem_q[rd_addr[k*AW +: AW]];
      rd_ready[k]         = (cnt[rd_addr[k*AW +: AW]] == '0);
`ifdef RF_MP_BYPASS_EN
      // Forwarding is suppressed in reset so reads stay at zero.
      for (int w = 0; w < NW; w++) begin
        if (rst && wr_en[w] && (rd_addr[k*AW +: AW] != ZERO_A) &&
            (wr_addr[w*AW +: AW] == rd_addr[k*AW +: AW])) begin
          rd_data[k*DW +: DW] = wr_data[w*DW +: DW];
          fwd_rel[k]          = wr_rel[w];
        end
      end
      if (fwd_rel[k] && (cnt[rd_addr[k*AW +: AW]] == CW'(1))) rd_ready[k] = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_rf_mp_sb.sv
module tb_rf_mp_sb;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int CW    = 2;
  localparam int CMAX  = 3;

  logic             clk;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_rel;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             alloc_stall;
  logic             flush;

  rf_mp_sb #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW), .CW(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_rel      (wr_rel),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .alloc_stall (alloc_stall),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                  tag;
    logic [NR-1:0][DW-1:0]  d;
    logic [NR-1:0]          rdy;
    logic                   stall;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [DW-1:0] mmem [DEPTH];
  int          mcnt [DEPTH];

  // Reference model: architectural register contents plus outstanding
  // write counts, advanced once per cycle after the expectation is taken.
  task automatic step(input logic r, input logic [NW-1:0] we,
                      input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                      input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                      input logic [NW-1:0] rl, input logic ae,
                      input logic [AW-1:0] aa, input logic fl,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input string tag);
    exp_t          e;
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];
    logic [AW-1:0] ra [NR];
    logic [AW-1:0] a;
    int            nrel;
    int            v;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    wr_rel = rl; alloc_en = ae; alloc_addr = aa; flush = fl;
    rd_addr = {ra1, ra0};
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; mcnt[i] = 0; end
    end
    e.tag = tag;
    for (int k = 0; k < NR; k++) begin
      a = ra[k];
      e.d[k]   = (a == 0) ? '0 : mmem[a];
      e.rdy[k] = (mcnt[a] == 0);
`ifdef RF_MP_BYPASS_EN
      if (r && a != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (we[w] && wa[w] == a) begin
            e.d[k]   = wd[w];
            e.rdy[k] = (mcnt[a] == 0) || (rl[w] && mcnt[a] == 1);
          end
        end
      end
`endif
    end
    nrel = 0;
    for (int w = 0; w < NW; w++) if (we[w] && rl[w] && wa[w] == aa) nrel++;
    e.stall = ae && (aa != 0) && (mcnt[aa] == CMAX) && (nrel == 0);
    sbq.push_back(e);
    if (r) begin
      for (int w = 0; w < NW; w++) if (we[w] && wa[w] != 0) mmem[wa[w]] = wd[w];
      if (fl) begin
        for (int i = 0; i < DEPTH; i++) mcnt[i] = 0;
      end else begin
        for (int i = 1; i < DEPTH; i++) begin
          v = mcnt[i];
          if (ae && !e.stall && aa == AW'(i)) v++;
          for (int w = 0; w < NW; w++) if (we[w] && rl[w] && wa[w] == AW'(i)) v--;
          if (v < 0) v = 0;
          if (v > CMAX) v = CMAX;
          mcnt[i] = v;
        end
      end
    end
  endtask

  task automatic rd(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input string tag);
    step(1'b1, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, ra0, ra1, tag);
  endtask

  task automatic alloc(input logic [AW-1:0] aa, input string tag);
    step(1'b1, '0, '0, '0, '0, '0, '0, 1'b1, aa, 1'b0, aa, '0, tag);
  endtask

  task automatic release0(input logic [AW-1:0] wa, input logic ae, input string tag);
    step(1'b1, 2'b01, wa, '0, 32'h0000_1000 + DW'(wa), '0, 2'b01, ae, wa, 1'b0, wa, '0, tag);
  endtask

  task automatic rand_step();
    logic [NW-1:0] we, rl;
    logic [AW-1:0] wa0, wa1, aa, ra0, ra1;
    int            avail;
    we  = NW'($urandom_range(3));
    wa0 = AW'($urandom_range(7));
    wa1 = AW'($urandom_range(7));
    rl  = '0;
    avail = mcnt[wa0];
    if (we[0] && wa0 != 0 && avail > 0 && $urandom_range(1) == 1) rl[0] = 1'b1;
    avail = mcnt[wa1] - ((rl[0] && wa0 == wa1) ? 1 : 0);
    if (we[1] && wa1 != 0 && avail > 0 && $urandom_range(1) == 1) rl[1] = 1'b1;
    aa  = AW'($urandom_range(7));
    ra0 = AW'($urandom_range(15));
    ra1 = AW'($urandom_range(7));
    step(1'b1, we, wa0, wa1, $urandom, $urandom, rl, ($urandom_range(3) != 0), aa,
         ($urandom_range(63) == 0), ra0, ra1, "rand");
  endtask

  // Monitor: outputs are combinational, so each queued expectation is
  // checked a short time after the inputs settle, well before the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < NR; k++) begin
          tests++;
          if (rd_data[k*DW +: DW] !== e.d[k]) begin
            fails++;
            $display("FAIL %s rd_data[%0d]: got %h expected %h", e.tag, k, rd_data[k*DW +: DW], e.d[k]);
          end
          tests++;
          if (rd_ready[k] !== e.rdy[k]) begin
            fails++;
            $display("FAIL %s rd_ready[%0d]: got %b expected %b", e.tag, k, rd_ready[k], e.rdy[k]);
          end
        end
        tests++;
        if (alloc_stall !== e.stall) begin
          fails++;
          $display("FAIL %s alloc_stall: got %b expected %b", e.tag, alloc_stall, e.stall);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_rel = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; mcnt[i] = 0; end

    step(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 4'd5, 4'd9, "reset");
    rd(4'd5, 4'd0, "post_reset");

    // Write latency on r5.
    step(1'b1, 2'b01, 4'd5, '0, 32'h1234_5678, '0, '0, 1'b0, '0, 1'b0, 4'd5, 4'd5, "wr_r5_same");
    rd(4'd5, 4'd5, "wr_r5_next");

    // Two ports writing r7 in the same cycle.
    step(1'b1, 2'b11, 4'd7, 4'd7, 32'hA, 32'hB, '0, 1'b0, '0, 1'b0, 4'd7, 4'd5, "wr_conflict");
    rd(4'd7, 4'd7, "wr_conflict_rd");

    // Scoreboard on r3.
    alloc(4'd3, "sb_alloc1");
    alloc(4'd3, "sb_alloc2");
    release0(4'd3, 1'b0, "sb_rel1");
    rd(4'd3, 4'd3, "sb_after_rel1");
    release0(4'd3, 1'b0, "sb_rel2");
    rd(4'd3, 4'd3, "sb_after_rel2");

    // Saturation on r9.
    alloc(4'd9, "sat_a1");
    alloc(4'd9, "sat_a2");
    alloc(4'd9, "sat_a3");
    alloc(4'd9, "sat_a4_stall");
    release0(4'd9, 1'b1, "sat_a4_rel");
    rd(4'd9, 4'd9, "sat_hold");
    release0(4'd9, 1'b0, "sat_drain1");
    release0(4'd9, 1'b0, "sat_drain2");
    rd(4'd9, 4'd9, "sat_one_left");
    release0(4'd9, 1'b0, "sat_drain3");
    rd(4'd9, 4'd9, "sat_clear");

    // Flush beats a same-cycle allocation.
    alloc(4'd4, "fl_a4_1");
    alloc(4'd4, "fl_a4_2");
    alloc(4'd6, "fl_a6");
    step(1'b1, '0, '0, '0, '0, '0, '0, 1'b1, 4'd4, 1'b1, 4'd4, 4'd6, "flush");
    rd(4'd4, 4'd6, "after_flush");

    // Register 0 is hardwired.
    step(1'b1, 2'b01, 4'd0, '0, 32'hDEAD_BEEF, '0, '0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, "r0_write");
    rd(4'd0, 4'd0, "r0_read");

    for (int n = 0; n < 1500; n++) rand_step();

    // Reset mid-run, then confirm everything reads cleared.
    alloc(4'd2, "pre_reset_alloc");
    step(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 4'd5, 4'd2, "mid_reset");
    rd(4'd7, 4'd2, "after_mid_reset");
    for (int n = 0; n < 300; n++) rand_step();
    rd(4'd0, 4'd1, "final");

    repeat (2) @(negedge clk);
    #4;
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
